// File: rtl/rll_key_loader.sv
// Serial key loader for RLL-locked cores: streams CHUNK_W-bit chunks plus an
// XOR parity chunk, commits a checked key, and locks out after repeated failures.
module rll_key_loader #(
  parameter int unsigned KEY_WIDTH  = 16,
  parameter int unsigned CHUNK_W    = 4,
  parameter int unsigned MAX_ERRORS = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [CHUNK_W-1:0]                  in_data,
  output logic [KEY_WIDTH-1:0]                key_out,
  output logic                                key_valid,
  output logic                                busy,
  output logic                                error,
  output logic [$clog2(MAX_ERRORS+1)-1:0]     err_count,
  output logic                                lockout
);

  localparam int unsigned NCHUNK = KEY_WIDTH / CHUNK_W;
  localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);
  localparam int unsigned ERR_W  = $clog2(MAX_ERRORS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    CHECK   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] staging_q, staging_d;
  logic [CHUNK_W-1:0]   parity_q, parity_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0] key_d;
  logic                 key_valid_d;
  logic                 error_d;
  logic [ERR_W-1:0]     err_count_d;
  logic [ERR_W-1:0]     err_inc;
  logic                 lockout_d;
  logic                 accept;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      staging_q <= '0;
      parity_q  <= '0;
      cnt_q     <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      error     <= 1'b0;
      err_count <= '0;
      lockout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      staging_q <= staging_d;
      parity_q  <= parity_d;
      cnt_q     <= cnt_d;
      key_out   <= key_d;
      key_valid <= key_valid_d;
      error     <= error_d;
      err_count <= err_count_d;
      lockout   <= lockout_d;
    end
  end

  // Next-state, datapath updates and state-decoded handshake outputs
  always_comb begin
    state_d     = state_q;
    staging_d   = staging_q;
    parity_d    = parity_q;
    cnt_d       = cnt_q;
    key_d       = key_out;
    key_valid_d = key_valid;
    error_d     = 1'b0;
    err_count_d = err_count;
    lockout_d   = lockout;
    in_ready    = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    err_inc     = err_count + ERR_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          staging_d = '0;
          parity_d  = '0;
          cnt_d     = '0;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid;
        // start outranks a simultaneous chunk, which is then dropped
        if (start) begin
          staging_d = '0;
          parity_d  = '0;
          cnt_d     = '0;
        end else if (accept) begin
          staging_d = {staging_q[KEY_WIDTH-CHUNK_W-1:0], in_data};
          parity_d  = parity_q ^ in_data;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NCHUNK - 1)) begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid;
        if (start) begin
          state_d   = LOAD;
          staging_d = '0;
          parity_d  = '0;
          cnt_d     = '0;
        end else if (accept) begin
          if (in_data == parity_q) begin
            key_d       = staging_q;
            key_valid_d = 1'b1;
            err_count_d = '0;
            state_d     = IDLE;
          end else begin
            key_d       = '0;
            key_valid_d = 1'b0;
            error_d     = 1'b1;
            err_count_d = err_inc;
            if (err_inc == ERR_W'(MAX_ERRORS)) begin
              lockout_d = 1'b1;
              state_d   = LOCKOUT;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      LOCKOUT: begin
        key_d       = '0;
        key_valid_d = 1'b0;
        lockout_d   = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader (16/4/3) with a chunk-level key model.
module tb_rll_key_loader;

  localparam int unsigned KW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned ME = 3;
  localparam int unsigned NC = KW / CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_data;
  logic [KW-1:0] key_out;
  logic          key_valid;
  logic          busy;
  logic          error;
  logic [1:0]    err_count;
  logic          lockout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: committed key, validity, consecutive failures, lockout
  logic [KW-1:0] m_key;
  logic          m_valid;
  int            m_err;
  logic          m_lock;

  rll_key_loader #(.KEY_WIDTH(KW), .CHUNK_W(CW), .MAX_ERRORS(ME)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .key_out(key_out),
    .key_valid(key_valid), .busy(busy), .error(error),
    .err_count(err_count), .lockout(lockout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] chunk_of(input logic [KW-1:0] k, input int i);
    return k[(NC-1-i)*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] xor_chunks(input logic [KW-1:0] k);
    logic [CW-1:0] p = '0;
    for (int i = 0; i < NC; i++) p ^= chunk_of(k, i);
    return p;
  endfunction

  task automatic idle_gap(input int cycles);
    in_valid = 1'b0;
    for (int g = 0; g < cycles; g++) tick();
  endtask

  task automatic send(input logic [CW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 4'hF;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    m_key = '0; m_valid = 1'b0; m_err = 0; m_lock = 1'b0;
    n_tests++;
    if ({key_out, key_valid, busy, error, err_count, lockout, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL %s: key=%h kv=%b busy=%b err=%b cnt=%0d lock=%b rdy=%b, want all zero",
               tag, key_out, key_valid, busy, error, err_count, lockout, in_ready);
    end
  endtask

  // Full load: start, NC key chunks with random stalls, then the parity chunk
  task automatic do_load(input logic [KW-1:0] key, input logic [CW-1:0] par,
                         input int max_gap, input string tag);
    logic [KW-1:0] prev_key;
    logic          pulse;
    prev_key = m_key;
    start = 1'b1; tick(); start = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: rdy=%b busy=%b, want 1 1", tag, in_ready, busy);
    end
    for (int i = 0; i < NC; i++) begin
      idle_gap($urandom_range(0, max_gap));
      send(chunk_of(key, i));
      if (i == 0) begin
        n_tests++;
        if (key_out !== prev_key || key_valid !== m_valid) begin
          n_fail++;
          $display("FAIL %s_hold: key=%h kv=%b, want %h %b", tag, key_out, key_valid, prev_key, m_valid);
        end
      end
    end
    idle_gap($urandom_range(0, max_gap));
    send(par);
    if (par == xor_chunks(key)) begin
      m_key = key; m_valid = 1'b1; m_err = 0; pulse = 1'b0;
    end else begin
      m_key = '0; m_valid = 1'b0; m_err++; pulse = 1'b1;
      if (m_err == ME) m_lock = 1'b1;
    end
    n_tests++;
    if (key_out !== m_key || key_valid !== m_valid || error !== pulse ||
        int'(err_count) != m_err || lockout !== m_lock || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_result: key=%h kv=%b err=%b cnt=%0d lock=%b busy=%b, want %h %b %b %0d %b 0",
               tag, key_out, key_valid, error, err_count, lockout, busy,
               m_key, m_valid, pulse, m_err, m_lock);
    end
    tick();
    n_tests++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse_width: error=%b, want 0", tag, error);
    end
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_nominal();
    do_load(16'hABCD, 4'h0, 0, "nominal");
  endtask

  task automatic test_bad_parity();
    do_load(16'h1234, 4'h5, 0, "bad_parity");
  endtask

  task automatic test_lockout();
    do_load(16'h5A5A, 4'h1, 1, "lock_bad2");
    do_load(16'h0F0F, 4'h0, 1, "lock_good");
    do_load(16'h1111, 4'h1, 1, "lock_bad_a");
    do_load(16'h2222, 4'h2, 1, "lock_bad_b");
    do_load(16'h3333, 4'h3, 1, "lock_bad_c");
    start = 1'b1; in_valid = 1'b1; in_data = 4'h6;
    tick();
    start = 1'b0; in_valid = 1'b0;
    tick();
    n_tests++;
    if (in_ready !== 1'b0 || lockout !== 1'b1 || err_count !== 2'd3 ||
        key_out !== '0 || key_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lockout_hold: rdy=%b lock=%b cnt=%0d key=%h kv=%b busy=%b, want 0 1 3 0000 0 0",
               in_ready, lockout, err_count, key_out, key_valid, busy);
    end
    do_reset("lockout_clear");
  endtask

  // Abort mid-load; the restarting start coincides with a chunk that must be dropped
  task automatic test_abort();
    start = 1'b1; tick(); start = 1'b0;
    send(4'hF);
    send(4'hE);
    start = 1'b1; in_valid = 1'b1; in_data = 4'h7;
    tick();
    start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < NC; i++) send(CW'(i + 1));
    send(4'h4);
    m_key = 16'h1234; m_valid = 1'b1; m_err = 0;
    n_tests++;
    if (key_out !== 16'h1234 || key_valid !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: key=%h kv=%b err=%b busy=%b, want 1234 1 0 0", key_out, key_valid, error, busy);
    end
  endtask

  task automatic test_backpressure();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < NC; i++) begin
      send(chunk_of(16'hABCD, i));
      idle_gap(2);
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_ready_%0d: rdy=%b, want 1", i, in_ready);
      end
    end
    send(4'h0);
    m_key = 16'hABCD; m_valid = 1'b1; m_err = 0;
    n_tests++;
    if (key_out !== 16'hABCD || key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure: key=%h kv=%b, want abcd 1", key_out, key_valid);
    end
    start = 1'b1; tick(); start = 1'b0;
    send(4'h9);
    send(4'h8);
    do_reset("mid_load_reset");
    tick();
    n_tests++;
    if (error !== 1'b0 || busy !== 1'b0 || key_out !== '0) begin
      n_fail++;
      $display("FAIL mid_load_reset_after: err=%b busy=%b key=%h, want 0 0 0000", error, busy, key_out);
    end
  endtask

  task automatic test_random();
    logic [KW-1:0] k;
    logic [CW-1:0] p;
    for (int it = 0; it < 30; it++) begin
      if (m_lock) begin
        start = 1'b1; tick(); start = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0 || lockout !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_locked_%0d: rdy=%b lock=%b, want 0 1", it, in_ready, lockout);
        end
        do_reset("rand_reset");
      end
      k = KW'($urandom);
      p = xor_chunks(k);
      if ($urandom_range(0, 9) < 4) p ^= CW'($urandom_range(1, 15));
      do_load(k, p, 3, "random");
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    m_key = '0; m_valid = 1'b0; m_err = 0; m_lock = 1'b0;
    tick();
    test_reset();
    test_nominal();
    test_bad_parity();
    test_lockout();
    test_abort();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
